// File: rtl/ndn_pkt_classifier.sv
// ndn_pkt_classifier: forwards a 64-bit word stream through a 4-deep FIFO while classifying NDN packets
module ndn_pkt_classifier #(
  parameter int CNT_WIDTH = 16,
  parameter logic [7:0] INTEREST_TYPE = 8'h05,
  parameter logic [7:0] DATA_TYPE = 8'h06
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_wr,
  input  logic [7:0]           in_ctrl,
  input  logic [63:0]          in_data,
  output logic                 in_rdy,
  output logic                 out_wr,
  output logic [7:0]           out_ctrl,
  output logic [63:0]          out_data,
  input  logic                 out_rdy,
  output logic [CNT_WIDTH-1:0] interest_cnt,
  output logic [CNT_WIDTH-1:0] data_cnt,
  output logic [CNT_WIDTH-1:0] other_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [1:0]           last_type
);
  typedef enum logic [1:0] {IDLE, BODY, DONE} state_t;
  logic [71:0] mem_q [4];
  logic [1:0] wp_q, rp_q, idx_q, last_q;
  logic [2:0] occ_q, occ_d;
  logic pop, push, drop, out_wr_q;
  logic [7:0] out_ctrl_q, type_byte;
  logic [63:0] out_data_q;
  logic [CNT_WIDTH-1:0] int_q, dat_q, oth_q, drp_q;
  state_t state_q;
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return &v ? v : v + CNT_WIDTH'(1);
  endfunction
  // a pop frees the head slot first, so a push into a full FIFO popping that cycle is not dropped
  always_comb begin
    pop = out_rdy && occ_q != 3'd0;
    push = in_wr && (occ_q != 3'd4 || pop);
    drop = in_wr && !push;
    occ_d = occ_q + {2'b0, push} - {2'b0, pop};
  end
  assign type_byte = in_data[31:24];
  assign in_rdy = occ_q < 3'd3;
  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {in_ctrl, in_data};
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
    end else begin
      wp_q <= wp_q + {1'b0, push};
      rp_q <= rp_q + {1'b0, pop};
      occ_q <= occ_d;
    end
  // registered output stage: holds the last word when nothing is popped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_wr_q <= 1'b0;
      out_ctrl_q <= '0;
      out_data_q <= '0;
    end else begin
      out_wr_q <= pop;
      if (pop) {out_ctrl_q, out_data_q} <= mem_q[rp_q];
    end
  // classifier sees every offered word, including ones the FIFO drops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      last_q <= '0;
      int_q <= '0;
      dat_q <= '0;
      oth_q <= '0;
      drp_q <= '0;
    end else begin
      if (drop) drp_q <= sat_inc(drp_q);
      if (in_wr && in_ctrl != 8'd0) begin
        if (state_q == BODY) begin
          oth_q <= sat_inc(oth_q);
          last_q <= 2'd3;
        end
        idx_q <= '0;
        state_q <= BODY;
      end else if (in_wr && state_q == BODY) begin
        if (idx_q == 2'd2) begin
          state_q <= DONE;
          if (type_byte == INTEREST_TYPE) begin
            int_q <= sat_inc(int_q);
            last_q <= 2'd1;
          end else if (type_byte == DATA_TYPE) begin
            dat_q <= sat_inc(dat_q);
            last_q <= 2'd2;
          end else begin
            oth_q <= sat_inc(oth_q);
            last_q <= 2'd3;
          end
        end else idx_q <= idx_q + 2'd1;
      end
    end
  assign out_wr = out_wr_q;
  assign out_ctrl = out_ctrl_q;
  assign out_data = out_data_q;
  assign interest_cnt = int_q;
  assign data_cnt = dat_q;
  assign other_cnt = oth_q;
  assign drop_cnt = drp_q;
  assign last_type = last_q;
endmodule

// File: tb/tb_ndn_pkt_classifier.sv
// tb_ndn_pkt_classifier: directed checks of forwarding, classification, backpressure, saturation and reset
module tb_ndn_pkt_classifier;
  logic clk = 1'b0, rst_n = 1'b0, in_wr = 1'b0, out_rdy = 1'b1;
  logic [7:0] in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic in_rdy, out_wr, s_in_rdy, s_out_wr;
  logic [7:0] out_ctrl, s_out_ctrl;
  logic [63:0] out_data, s_out_data;
  logic [15:0] interest_cnt, data_cnt, other_cnt, drop_cnt;
  logic [1:0] s_interest_cnt, s_data_cnt, s_other_cnt, s_drop_cnt, last_type, s_last_type;
  int n_cmp = 0, n_bad = 0, fwd = 0;
  logic [71:0] exp_q [$];
  always #5 clk = ~clk;
  ndn_pkt_classifier dut (
    .clk(clk), .rst_n(rst_n), .in_wr(in_wr), .in_ctrl(in_ctrl), .in_data(in_data), .in_rdy(in_rdy),
    .out_wr(out_wr), .out_ctrl(out_ctrl), .out_data(out_data), .out_rdy(out_rdy),
    .interest_cnt(interest_cnt), .data_cnt(data_cnt), .other_cnt(other_cnt), .drop_cnt(drop_cnt),
    .last_type(last_type)
  );
  ndn_pkt_classifier #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_wr(in_wr), .in_ctrl(in_ctrl), .in_data(in_data), .in_rdy(s_in_rdy),
    .out_wr(s_out_wr), .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_rdy(out_rdy),
    .interest_cnt(s_interest_cnt), .data_cnt(s_data_cnt), .other_cnt(s_other_cnt), .drop_cnt(s_drop_cnt),
    .last_type(s_last_type)
  );
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_wr === 1'b1) begin
      fwd++;
      chk("word_expected", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) chk("fwd_word", {out_ctrl, out_data}, exp_q.pop_front());
    end
  endtask
  task automatic push(input logic [7:0] c, input logic [63:0] d, input bit acc);
    in_wr = 1'b1;
    in_ctrl = c;
    in_data = d;
    if (acc) exp_q.push_back({c, d});
    tick();
    in_wr = 1'b0;
    in_ctrl = '0;
    in_data = '0;
  endtask
  initial begin
    #12;
    chk("rst_out_wr", 72'(out_wr), 72'd0);
    chk("rst_in_rdy", 72'(in_rdy), 72'd1);
    chk("rst_counters", 72'({interest_cnt, data_cnt, other_cnt, drop_cnt}), 72'd0);
    chk("rst_last_type", 72'(last_type), 72'd0);
    rst_n = 1'b1;
    push(8'h01, 64'hAAAA_0000_0000_0001, 1);
    chk("lat_e0_out_wr", 72'(out_wr), 72'd0);
    push(8'h00, 64'h4500_0027_1aac_4000, 1);
    chk("lat_e1_out_wr", 72'(out_wr), 72'd1);
    chk("lat_e1_word", {out_ctrl, out_data}, {8'h01, 64'hAAAA_0000_0000_0001});
    push(8'h00, 64'h40fc_212d_7f00_0001, 1);
    push(8'h00, 64'h7f00_0001_0511_0709, 1);
    chk("int_cnt", 72'(interest_cnt), 72'd1);
    chk("int_last", 72'(last_type), 72'd1);
    tick();
    tick();
    chk("int_drained", 72'(exp_q.size()), 72'd0);
    chk("out_hold", {out_wr, out_ctrl, out_data}, {1'b0, 8'h00, 64'h7f00_0001_0511_0709});
    fwd = 0;
    push(8'hFF, 64'hBBBB_0000_0000_0002, 1);
    push(8'h00, 64'h4500_01e5_1c63_4000, 1);
    push(8'h00, 64'h40fc_1db8_7f00_0001, 1);
    push(8'h00, 64'h7f00_0001_06fd_01cd, 1);
    for (int i = 0; i < 58; i++) push(8'h00, {32'hB0D1_0000, 32'(i) ^ 32'h5A5A_A5A5}, 1);
    tick();
    tick();
    chk("data_fwd_count", 72'(fwd), 72'd62);
    chk("data_cnt", 72'(data_cnt), 72'd1);
    chk("data_last", 72'(last_type), 72'd2);
    chk("data_int_kept", 72'(interest_cnt), 72'd1);
    push(8'h01, 64'hCCCC_0000_0000_0003, 1);
    push(8'h00, 64'h0000_0000_0500_0000, 1);
    push(8'h00, 64'h0000_0000_0500_0000, 1);
    push(8'h02, 64'hCCCC_0000_0000_0004, 1);
    chk("trunc_other", 72'(other_cnt), 72'd1);
    chk("trunc_last", 72'(last_type), 72'd3);
    chk("trunc_int_kept", 72'(interest_cnt), 72'd1);
    push(8'h00, 64'h0000_0000_0600_0000, 1);
    push(8'h00, 64'h0000_0000_0600_0000, 1);
    push(8'h00, 64'h0000_0000_0500_0000, 1);
    chk("reidx_int", 72'(interest_cnt), 72'd2);
    chk("reidx_data", 72'(data_cnt), 72'd1);
    chk("reidx_last", 72'(last_type), 72'd1);
    push(8'h00, 64'h0000_0000_0600_0000, 1);
    chk("done_ignored", 72'(data_cnt), 72'd1);
    tick();
    tick();
    chk("trunc_drained", 72'(exp_q.size()), 72'd0);
    out_rdy = 1'b0;
    push(8'h00, 64'hD000_0000_0000_0001, 1);
    chk("bp_rdy1", 72'(in_rdy), 72'd1);
    push(8'h00, 64'hD000_0000_0000_0002, 1);
    chk("bp_rdy2", 72'(in_rdy), 72'd1);
    push(8'h01, 64'hD000_0000_0000_0003, 1);
    chk("bp_rdy3", 72'(in_rdy), 72'd0);
    push(8'h00, 64'hD000_0000_0000_0004, 1);
    push(8'h00, 64'hD000_0000_0000_0005, 0);
    push(8'h00, 64'hD000_0000_0600_0006, 0);
    chk("bp_out_wr", 72'(out_wr), 72'd0);
    chk("bp_drop", 72'(drop_cnt), 72'd2);
    chk("bp_fsm_sees_dropped", 72'(data_cnt), 72'd2);
    fwd = 0;
    out_rdy = 1'b1;
    push(8'h00, 64'hD000_0000_0000_0007, 1);
    chk("pushpop_no_drop", 72'(drop_cnt), 72'd2);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_fwd_count", 72'(fwd), 72'd5);
    chk("bp_drained", 72'(exp_q.size()), 72'd0);
    out_rdy = 1'b0;
    push(8'h01, 64'hEEEE_0000_0000_0001, 1);
    push(8'h00, 64'hE000_0000_0000_0001, 1);
    push(8'h00, 64'hE000_0000_0000_0002, 1);
    push(8'h00, 64'hE000_0000_0500_0003, 1);
    chk("pre_rst_int", 72'(interest_cnt), 72'd3);
    out_rdy = 1'b1;
    tick();
    chk("pre_rst_out_wr", 72'(out_wr), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", {out_wr, out_ctrl, out_data}, 72'd0);
    chk("arst_counters", 72'({interest_cnt, data_cnt, other_cnt, drop_cnt}), 72'd0);
    chk("arst_last", 72'(last_type), 72'd0);
    chk("arst_in_rdy", 72'(in_rdy), 72'd1);
    exp_q.delete();
    #2 rst_n = 1'b1;
    push(8'h00, 64'hF000_0000_0500_0000, 1);
    tick();
    tick();
    chk("post_rst_int", 72'(interest_cnt), 72'd0);
    chk("post_rst_last", 72'(last_type), 72'd0);
    chk("post_rst_drained", 72'(exp_q.size()), 72'd0);
    for (int p = 0; p < 5; p++) begin
      push(8'h01, {32'h5A70_0000, 32'(p)}, 1);
      push(8'h00, 64'h4500_0027_1aac_4000, 1);
      push(8'h00, 64'h40fc_212d_7f00_0001, 1);
      push(8'h00, 64'h7f00_0001_0511_0709, 1);
    end
    tick();
    tick();
    chk("sat_wide_int", 72'(interest_cnt), 72'd5);
    chk("sat_narrow_int", 72'(s_interest_cnt), 72'd3);
    chk("sat_narrow_last", 72'(s_last_type), 72'd1);
    chk("sat_drained", 72'(exp_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ndn_pkt_classifier.md
NDN_PKT_CLASSIFIER -- requirements
Module: ndn_pkt_classifier

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of each packet counter.
REQ-002 Parameter INTEREST_TYPE, default 8'h05, NDN TLV type byte for Interest.
REQ-003 Parameter DATA_TYPE, default 8'h06, NDN TLV type byte for Data.
REQ-004 Single clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_wr  input  1  upstream word valid.
REQ-008 in_ctrl  input  8  upstream control byte; nonzero marks a packet header word.
REQ-009 in_data  input  64  upstream data word.
REQ-010 in_rdy  output  1  block can accept a word.
REQ-011 out_wr  output  1  downstream word valid.
REQ-012 out_ctrl  output  8  forwarded control byte.
REQ-013 out_data  output  64  forwarded data word.
REQ-014 out_rdy  input  1  downstream can accept a word.
REQ-015 interest_cnt, data_cnt, other_cnt  output  CNT_WIDTH each  classified packet counts.
REQ-016 drop_cnt  output  CNT_WIDTH  words lost to FIFO overflow.
REQ-017 last_type  output  2  class of last packet: 0 none, 1 interest, 2 data, 3 other.

Function
REQ-018 Word accepted at a rising edge when in_wr=1 and FIFO not full; 4-entry FIFO stores {in_ctrl, in_data} in order.
REQ-019 in_rdy = 1 when FIFO occupancy < 3 (combinational from occupancy; one slot slack).
REQ-020 in_wr=1 with FIFO full (4): word discarded, drop_cnt +1; classification FSM still samples the word.
REQ-021 Output registered: at each edge, if out_rdy=1 and FIFO non-empty, pop head into out_ctrl/out_data, out_wr<=1; otherwise out_wr<=0, out_ctrl/out_data hold.
REQ-022 Latency: word accepted at edge E into empty FIFO with out_rdy=1 appears with out_wr=1 after edge E+1.
REQ-023 Simultaneous push and pop on a full FIFO: pop takes effect first; push accepted, no drop.
REQ-024 Forwarding is transparent: ctrl and data bits unmodified, order preserved.
REQ-025 FSM states IDLE, BODY, DONE; operates on every in_wr=1 word (FIFO-independent).
REQ-026 Any word with in_ctrl!=0: if state BODY, other_cnt +1 and last_type<=3 (truncated packet); then body index<=0, state<=BODY.
REQ-027 In BODY, word with in_ctrl==0 and index 0 or 1: index +1.
REQ-028 In BODY, word with in_ctrl==0 and index 2: type byte = in_data[31:24]; INTEREST_TYPE -> interest_cnt +1, last_type<=1; DATA_TYPE -> data_cnt +1, last_type<=2; else other_cnt +1, last_type<=3; state<=DONE.
REQ-029 In IDLE or DONE, words with in_ctrl==0 ignored by FSM.
REQ-030 All counters saturate at 2^CNT_WIDTH-1; no wrap.
REQ-031 Counter updates visible the cycle after the triggering edge.

Reset
REQ-032 rst_n=0 immediately forces: FIFO empty, out_wr=0, out_ctrl=0, out_data=0, all counters 0, last_type=0, FSM IDLE, index 0.
REQ-033 Reset mid-packet discards FIFO contents and partial classification; words after release before a header word are not classified.
REQ-034 in_rdy=1 during and after reset (FIFO empty).

Verification
REQ-035 Interest: header ctrl=1 then 450000271aac4000, 40fc212d7f000001, 7f00000105110709, out_rdy=1 -> interest_cnt=1, last_type=1, all four words on out_* in order, out_wr first high after edge E+1.
REQ-036 Data: header then 450001e51c634000, 40fc1db87f000001, 7f00000106fd01cd + 58 body words -> data_cnt=1, last_type=2, 62 words forwarded unchanged.
REQ-037 Truncated: header, two body words, new header -> other_cnt=1, last_type=3, FSM back in BODY index 0.
REQ-038 Backpressure: out_rdy=0, 6 consecutive in_wr words -> in_rdy low after 3rd, drop_cnt=2, first 4 words emerge after out_rdy=1.
REQ-039 Saturation: CNT_WIDTH=2, 5 Interest packets -> interest_cnt=3.
REQ-040 Reset: rst_n low while FIFO holds 3 words -> out_wr=0, counters 0, no stale word emitted after release.
